// File: rtl/decode_queue.sv
// Instruction buffer plus RV32I decode between fetch and dispatch.
// A DEPTH-entry FIFO holds fetched instructions; the head entry is decoded combinationally.
module decode_queue #(
  parameter int DEPTH   = 8,
  parameter int ORDER_W = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_inst,
  input  logic [31:0]                in_pc,
  input  logic [ORDER_W-1:0]         in_order,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_inst,
  output logic [31:0]                out_pc,
  output logic [ORDER_W-1:0]         out_order,
  output logic [6:0]                 out_opcode,
  output logic [2:0]                 out_funct3,
  output logic [6:0]                 out_funct7,
  output logic [4:0]                 out_rs1_addr,
  output logic [4:0]                 out_rs2_addr,
  output logic [4:0]                 out_rd_addr,
  output logic [31:0]                out_imm,
  output logic [3:0]                 out_aluop,
  output logic                       out_regf_we,
  output logic                       out_use_rs1,
  output logic                       out_use_rs2,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_NONE = 4'd15;

  function automatic logic signed [31:0] imm_i(input logic [31:0] i);
    return {{20{i[31]}}, i[31:20]};
  endfunction

  function automatic logic signed [31:0] imm_s(input logic [31:0] i);
    return {{20{i[31]}}, i[31:25], i[11:7]};
  endfunction

  function automatic logic signed [31:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic signed [31:0] imm_u(input logic [31:0] i);
    return {i[31:12], 12'b0};
  endfunction

  function automatic logic signed [31:0] imm_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  logic [31:0]        inst_mem  [DEPTH];
  logic [31:0]        pc_mem    [DEPTH];
  logic [ORDER_W-1:0] order_mem [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic enq, deq;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;
  assign count     = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + AW'(1);
      if (deq) head_d = head_q + AW'(1);
      if (enq && !deq)      count_d = count_q + CW'(1);
      else if (deq && !enq) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (enq && !flush) begin
      inst_mem[tail_q]  <= in_inst;
      pc_mem[tail_q]    <= in_pc;
      order_mem[tail_q] <= in_order;
    end
  end

  logic [31:0] h;
  logic        ill;
  assign h = inst_mem[head_q];

  always_comb begin
    out_inst     = '0;
    out_pc       = '0;
    out_order    = '0;
    out_opcode   = '0;
    out_funct3   = '0;
    out_funct7   = '0;
    out_rs1_addr = '0;
    out_rs2_addr = '0;
    out_rd_addr  = '0;
    out_imm      = '0;
    out_aluop    = '0;
    out_regf_we  = 1'b0;
    out_use_rs1  = 1'b0;
    out_use_rs2  = 1'b0;
    out_illegal  = 1'b0;
    ill          = 1'b0;
    if (out_valid) begin
      out_inst     = h;
      out_pc       = pc_mem[head_q];
      out_order    = order_mem[head_q];
      out_opcode   = h[6:0];
      out_funct3   = h[14:12];
      out_funct7   = h[31:25];
      out_rs1_addr = h[19:15];
      out_rs2_addr = h[24:20];
      out_rd_addr  = h[11:7];
      out_aluop    = ALU_ADD;
      case (h[6:0])
        OP_LUI, OP_AUIPC: begin
          out_imm     = imm_u(h);
          out_regf_we = 1'b1;
        end
        OP_JAL: begin
          out_imm     = imm_j(h);
          out_regf_we = 1'b1;
        end
        OP_JALR, OP_LOAD: begin
          out_imm     = imm_i(h);
          out_use_rs1 = 1'b1;
          out_regf_we = 1'b1;
        end
        OP_BRANCH: begin
          out_imm     = imm_b(h);
          out_use_rs1 = 1'b1;
          out_use_rs2 = 1'b1;
        end
        OP_STORE: begin
          out_imm     = imm_s(h);
          out_use_rs1 = 1'b1;
          out_use_rs2 = 1'b1;
        end
        OP_IMM: begin
          out_imm     = imm_i(h);
          out_use_rs1 = 1'b1;
          out_regf_we = 1'b1;
          out_aluop   = {1'b0, h[14:12]};
          if (h[14:12] == 3'b101 && h[31:25] == F7_ALT) out_aluop = ALU_SRA;
        end
        OP_REG: begin
          out_use_rs1 = 1'b1;
          out_use_rs2 = 1'b1;
          out_regf_we = 1'b1;
          // add/sub and srl/sra share funct3; funct7 picks the variant
          if (h[31:25] == F7_BASE)                              out_aluop = {1'b0, h[14:12]};
          else if (h[31:25] == F7_ALT && h[14:12] == 3'b000)    out_aluop = ALU_SUB;
          else if (h[31:25] == F7_ALT && h[14:12] == 3'b101)    out_aluop = ALU_SRA;
          else                                                  ill       = 1'b1;
        end
        default: ill = 1'b1;
      endcase
      if (ill) begin
        out_illegal = 1'b1;
        out_regf_we = 1'b0;
        out_use_rs1 = 1'b0;
        out_use_rs2 = 1'b0;
        out_imm     = '0;
        out_aluop   = ALU_NONE;
      end
      if (h[11:7] == 5'd0) out_regf_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: table of encodings streamed through a scoreboard, plus
// latency, fill/drain, flush and asynchronous-reset sequences.
module tb_decode_queue;

  localparam int DEPTH   = 8;
  localparam int ORDER_W = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]        in_inst, in_pc;
  logic [ORDER_W-1:0] in_order;
  logic [31:0]        out_inst, out_pc, out_imm;
  logic [ORDER_W-1:0] out_order;
  logic [6:0]         out_opcode, out_funct7;
  logic [2:0]         out_funct3;
  logic [4:0]         out_rs1_addr, out_rs2_addr, out_rd_addr;
  logic [3:0]         out_aluop;
  logic               out_regf_we, out_use_rs1, out_use_rs2, out_illegal;
  logic [3:0]         count;

  decode_queue #(.DEPTH(DEPTH), .ORDER_W(ORDER_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_order(in_order),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_order(out_order),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
    .out_imm(out_imm), .out_aluop(out_aluop),
    .out_regf_we(out_regf_we), .out_use_rs1(out_use_rs1), .out_use_rs2(out_use_rs2),
    .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        we, u1, u2, ill;
  } vec_t;

  typedef struct {
    vec_t               v;
    logic [31:0]        pc;
    logic [ORDER_W-1:0] order;
  } exp_t;

  int   checks = 0;
  int   passed = 0;
  exp_t sb[$];
  exp_t cur;
  vec_t vecs[19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] imm, input logic [3:0] alu,
                              input logic we, input logic u1, input logic u2, input logic ill);
    vec_t v;
    v.inst = inst; v.imm = imm; v.alu = alu; v.we = we; v.u1 = u1; v.u2 = u2; v.ill = ill;
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic [31:0] pc, input logic [ORDER_W-1:0] ord);
    in_valid  = 1'b1;
    in_inst   = v.inst;
    in_pc     = pc;
    in_order  = ord;
    cur.v     = v;
    cur.pc    = pc;
    cur.order = ord;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: accepted instructions are queued, dequeued ones are compared in order.
  always @(negedge clk) begin
    if (!rst || flush) begin
      sb.delete();
    end else begin
      if (!out_valid)
        chk("idle_zero", 64'({out_aluop, out_imm, out_pc, out_regf_we, out_illegal}), 64'(0));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_pc", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pc",      64'(out_pc),      64'(e.pc));
          chk("order",   64'(out_order),   64'(e.order));
          chk("inst",    64'(out_inst),    64'(e.v.inst));
          chk("imm",     64'(out_imm),     64'(e.v.imm));
          chk("aluop",   64'(out_aluop),   64'(e.v.alu));
          chk("regf_we", 64'(out_regf_we), 64'(e.v.we));
          chk("use_rs1", 64'(out_use_rs1), 64'(e.v.u1));
          chk("use_rs2", 64'(out_use_rs2), 64'(e.v.u2));
          chk("illegal", 64'(out_illegal), 64'(e.v.ill));
        end
      end
      if (in_valid && in_ready) sb.push_back(cur);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(32'hFFF00093, 32'hFFFFFFFF, 4'd0,  1, 1, 0, 0);
    vecs[1]  = mk(32'h4020D093, 32'h00000402, 4'd9,  1, 1, 0, 0);
    vecs[2]  = mk(32'h402081B3, 32'h00000000, 4'd8,  1, 1, 1, 0);
    vecs[3]  = mk(32'h00208463, 32'h00000008, 4'd0,  0, 1, 1, 0);
    vecs[4]  = mk(32'h00000000, 32'h00000000, 4'd15, 0, 0, 0, 1);
    vecs[5]  = mk(32'h00000013, 32'h00000000, 4'd0,  0, 1, 0, 0);
    vecs[6]  = mk(32'h123452B7, 32'h12345000, 4'd0,  1, 0, 0, 0);
    vecs[7]  = mk(32'hFFDFF0EF, 32'hFFFFFFFC, 4'd0,  1, 0, 0, 0);
    vecs[8]  = mk(32'hFE20AC23, 32'hFFFFFFF8, 4'd0,  0, 1, 1, 0);
    vecs[9]  = mk(32'h4062D233, 32'h00000000, 4'd9,  1, 1, 1, 0);
    vecs[10] = mk(32'h0262F233, 32'h00000000, 4'd15, 0, 0, 0, 1);
    vecs[11] = mk(32'hFFF43393, 32'hFFFFFFFF, 4'd3,  1, 1, 0, 0);
    vecs[12] = mk(32'h01012483, 32'h00000010, 4'd0,  1, 1, 0, 0);
    vecs[13] = mk(32'h00008067, 32'h00000000, 4'd0,  0, 1, 0, 0);
    vecs[14] = mk(32'hFFFFF517, 32'hFFFFF000, 4'd0,  1, 0, 0, 0);
    vecs[15] = mk(32'h0030D093, 32'h00000003, 4'd5,  1, 1, 0, 0);
    vecs[16] = mk(32'hFE2098E3, 32'hFFFFFFF0, 4'd0,  0, 1, 1, 0);
    vecs[17] = mk(32'h0020E1B3, 32'h00000000, 4'd6,  1, 1, 1, 0);
    vecs[18] = mk(32'h002081B3, 32'h00000000, 4'd0,  1, 1, 1, 0);

    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0; in_order = '0;
    cur.v = vecs[0]; cur.pc = '0; cur.order = '0;
    step(); step();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_count",     64'(count),     64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    rst = 1'b1;
    step();

    // single enqueue: visible right after the accepting edge
    drive(vecs[0], 32'h1ECEB000, 64'd100);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_out_valid", 64'(out_valid),    64'(1));
    chk("lat_rd",        64'(out_rd_addr),  64'(1));
    chk("lat_imm",       64'(out_imm),      64'hFFFFFFFF);
    chk("lat_aluop",     64'(out_aluop),    64'(0));
    chk("lat_we",        64'(out_regf_we),  64'(1));
    chk("lat_use_rs1",   64'(out_use_rs1),  64'(1));
    chk("lat_use_rs2",   64'(out_use_rs2),  64'(0));
    chk("lat_count",     64'(count),        64'(1));
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // stream the encoding table back to back with dispatch always ready
    out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i], 32'h1000 + 32'(4 * i), 64'(i));
      step();
    end
    in_valid = 1'b0;
    for (int t = 0; t < 20 && count != 0; t++) step();
    chk("stream_drained", 64'(count), 64'(0));

    // fill to full with dispatch stalled; the ninth is refused
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      drive(vecs[0], 32'(4 * k), 64'(k));
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_count",    64'(count),    64'(8));
    chk("full_in_ready", 64'(in_ready), 64'(0));
    chk("full_head_pc",  64'(out_pc),   64'(0));
    step();
    out_ready = 1'b1;
    drive(vecs[2], 32'h99, 64'h99);
    @(negedge clk);
    chk("full_rdy_in_ready", 64'(in_ready), 64'(0));
    step();
    in_valid = 1'b0;
    repeat (7) step();
    @(negedge clk);
    chk("drain_count", 64'(count),     64'(0));
    chk("drain_valid", 64'(out_valid), 64'(0));
    step();

    // flush with a same-cycle enqueue and dequeue
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(vecs[k], 32'h2000 + 32'(4 * k), 64'(200 + k));
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_flush_count", 64'(count), 64'(5));
    step();
    drive(vecs[1], 32'hDEAD0, 64'hDEAD);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_count", 64'(count),     64'(0));
    chk("flush_valid", 64'(out_valid), 64'(0));
    repeat (3) step();

    // asynchronous reset in the middle of traffic
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(vecs[k + 6], 32'h3000 + 32'(4 * k), 64'(300 + k));
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_count", 64'(count), 64'(3));
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_count",     64'(count),     64'(0));
    chk("arst_in_ready",  64'(in_ready),  64'(1));
    chk("arst_aluop",     64'(out_aluop), 64'(0));
    @(negedge clk);
    #2;
    rst = 1'b1;
    step();

    // traffic resumes cleanly after reset
    out_ready = 1'b1;
    drive(vecs[9], 32'h4000, 64'd400);
    step();
    drive(vecs[11], 32'h4004, 64'd401);
    step();
    in_valid = 1'b0;
    for (int t = 0; t < 10 && count != 0; t++) step();
    step();
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised decode stage with an instruction buffer. It sits between fetch and dispatch in the out-of-order RV32I core. Fetched instructions (inst, pc, order) are accepted into a DEPTH-entry FIFO through a valid/ready handshake. The head entry is fully decoded (fields, sign-extended immediate for every RV32I format, ALU op, register-use and write-enable flags, illegal flag) and presented to dispatch through a second valid/ready handshake. A flush input discards all buffered instructions.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥ 2
- ORDER_W, 64, width of the retirement order tag
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  queue accepts; = !full
- in_inst / in_pc  in  32 / 32  instruction word, its PC
- in_order  in  ORDER_W  order tag
- flush  in  1  discard all entries
- out_valid  out  1  head entry valid; = !empty
- out_ready  in  1  dispatch takes head
- out_inst / out_pc / out_order  out  32 / 32 / ORDER_W  head entry payload
- out_opcode, out_funct3, out_funct7  out  7, 3, 7  inst[6:0], [14:12], [31:25]
- out_rs1_addr, out_rs2_addr, out_rd_addr  out  5 each  inst[19:15], [24:20], [11:7]
- out_imm  out  32  sign-extended immediate for the format
- out_aluop  out  4  add 0, sll 1, slt 2, sltu 3, xor 4, srl 5, or 6, and 7, sub 8, sra 9, none 15
- out_regf_we, out_use_rs1, out_use_rs2, out_illegal  out  1 each  control flags
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Enqueue when in_valid && in_ready: write at tail, advance tail. Dequeue when out_valid && out_ready: advance head.
- Pointers wrap modulo DEPTH. count tracks occupancy: +1 on enqueue only, −1 on dequeue only, unchanged when both occur.
- Decode is combinational from the head entry's stored inst. When out_valid=0, every out_* is 0, out_aluop included.
- lui, auipc: U imm; we=1; aluop add.
- jal: J imm; we=1; add.
- jalr: I imm; use_rs1; we=1; add.
- branch 1100011: B imm; use_rs1, use_rs2; we=0; add.
- load: I imm; use_rs1; we=1; add.
- store: S imm; use_rs1, use_rs2; we=0; add.
- op-imm 0010011: I imm; use_rs1; we=1; aluop = funct3 code. For funct3=101: sra if funct7=0100000, else srl.
- op-reg 0110011: imm 0; use_rs1, use_rs2; we=1.
  - funct3 000: add (funct7=0000000) or sub (0100000).
  - funct3 101: srl (0000000) or sra (0100000).
  - Other funct3: funct3 code, requires funct7=0000000.
  - Any other funct7: illegal.
- Any other opcode: illegal.
- Illegal entries: out_illegal=1, we=0, use_*=0, imm=0, aluop none. They are still dequeued normally.
- out_rd_addr=0 forces out_regf_we=0.

## Timing
- Reset (rst=0, asynchronous): head=tail=count=0, out_valid=0, in_ready=1, all decoded outputs 0. Mid-operation reset drops all contents immediately.
- Latency: an instruction enqueued at edge N is visible on out_* after edge N. No empty-queue bypass.
- Full: in_ready=0 even if out_ready=1 in the same cycle (no enqueue-on-full). in_* are ignored.
- Empty: out_valid=0. A simultaneous enqueue does not dequeue.
- flush=1: on the next edge head=tail=count=0. It overrides any same-cycle enqueue and dequeue; the in-flight instruction is dropped. in_ready and out_valid stay combinational from current state during the flush cycle.
- Throughput: one enqueue and one dequeue per cycle sustained.

## Test plan
- Reset: assert rst=0 mid-traffic with count=3 → immediately out_valid=0, count=0, in_ready=1, out_aluop=0.
- Enqueue 0xFFF00093 (addi x1,x0,-1), pc 0x1ECEB000 → next cycle: out_valid=1, out_rd_addr=1, out_imm=0xFFFFFFFF, out_aluop=0, out_regf_we=1, out_use_rs1=1, out_use_rs2=0.
- Back-to-back 0x4020D093 (srai x1,x1,2) then 0x402081B3 (sub x3,x1,x2), out_ready=1:
  - srai → aluop 9, imm 0x00000402.
  - sub → aluop 8, use_rs1=use_rs2=1, imm 0.
- Fill/drain (DEPTH=8, out_ready=0): 9 enqueues with pc 0..0x20 → count=8, in_ready=0, 9th dropped. Then out_ready=1 → pcs 0x0..0x1C in order, count reaches 0.
- Flush at count=5 with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0; the dropped instruction never appears.
- Encodings:
  - 0x00208463 (beq x1,x2,8) → imm 0x00000008, we=0, use_rs1=use_rs2=1.
  - 0x00000000 → illegal=1, we=0, aluop 15.
  - 0x00000013 (addi x0) → we=0.
